// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between an issuing client and alu_op_sequencer.
// master = client side (issues commands, consumes responses); slave = sequencer side.
interface alu_op_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int REG_AW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic [WIDTH-1:0]  cmd_imm;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic [2:0]        rsp_flags;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for a combinational 4-bit ALU: accepts register-addressed commands, drives the
// ALU for one EXEC cycle, writes the result back and returns it on a response handshake.
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int NREG   = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  output logic [2:0]        o_alu_ch,
  input  logic [WIDTH-1:0]  i_alu_f,
  input  logic              i_zero_f,
  input  logic              i_over_f,
  input  logic              i_cout_f
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_regs [NREG];
  logic              r_load;
  logic [REG_AW-1:0] r_rd;
  logic [WIDTH-1:0]  r_imm;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [2:0]        r_alu_ch;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;
  logic [2:0]        r_rsp_flags;
  logic              w_cmd_fire;

  // Ready is a pure decode of the state register, so rsp_ready never reaches it combinationally.
  assign bus.cmd_ready = (r_state == ST_IDLE) & ~rst;
  assign w_cmd_fire    = bus.cmd_valid & bus.cmd_ready;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flags = r_rsp_flags;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_ch      = r_alu_ch;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; the
  // register file is reset explicitly because a reset must leave every register reading 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_load      <= 1'b0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ch    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_load <= bus.cmd_load;
            r_rd   <= bus.cmd_rd;
            r_imm  <= bus.cmd_imm;
            // No writeback can land between acceptance and EXEC, so reading the operands here
            // presents exactly the EXEC-time register values, and holds them afterwards.
            if (!bus.cmd_load) begin
              r_alu_a  <= r_regs[bus.cmd_rs1];
              r_alu_b  <= r_regs[bus.cmd_rs2];
              r_alu_ch <= bus.cmd_op;
            end
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (r_load) begin
            r_regs[r_rd] <= r_imm;
            r_rsp_data   <= r_imm;
            r_rsp_flags  <= {(r_imm == '0), 2'b00};
          end else begin
            r_regs[r_rd] <= i_alu_f;
            r_rsp_data   <= i_alu_f;
            r_rsp_flags  <= {i_zero_f, i_over_f, i_cout_f};
          end
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU on the alu_* side.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_f;
  logic [2:0] alu_ch;
  logic       zero_f, over_f, cout_f;
  logic [4:0] alu_sum;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer_if #(.WIDTH(4), .REG_AW(2)) bus ();

  alu_op_sequencer #(.WIDTH(4), .NREG(4), .REG_AW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .o_alu_a  (alu_a),
    .o_alu_b  (alu_b),
    .o_alu_ch (alu_ch),
    .i_alu_f  (alu_f),
    .i_zero_f (zero_f),
    .i_over_f (over_f),
    .i_cout_f (cout_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NOTE: every output of a combinational block gets a default first so no latch is implied.
  always_comb begin
    alu_f   = '0;
    over_f  = 1'b0;
    cout_f  = 1'b0;
    alu_sum = '0;
    case (alu_ch)
      3'b000: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f   = alu_sum[3:0];
        cout_f  = alu_sum[4];
        over_f  = (alu_a[3] == alu_b[3]) && (alu_f[3] != alu_a[3]);
      end
      3'b001: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_f   = alu_sum[3:0];
        cout_f  = alu_sum[4];
        over_f  = (alu_a[3] != alu_b[3]) && (alu_f[3] != alu_a[3]);
      end
      3'b010:  alu_f = ~alu_a;
      3'b011:  alu_f = alu_a & alu_b;
      3'b100:  alu_f = alu_a | alu_b;
      3'b101:  alu_f = alu_a ^ alu_b;
      3'b110:  alu_f = ($signed(alu_a) < $signed(alu_b)) ? 4'd1 : 4'd0;
      default: alu_f = (alu_a == alu_b) ? 4'd1 : 4'd0;
    endcase
    zero_f = (alu_f == 4'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command, checks EXEC and RESP timing, optionally stalls the response for
  // `hold` cycles, then completes the handshake. Only flag bits set in fmask are compared.
  task automatic do_cmd(input string tag, input bit load, input logic [2:0] op,
                        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [3:0] imm, input logic [3:0] exp_data,
                        input logic [2:0] exp_flags, input logic [2:0] fmask, input int hold);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".idle_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check({tag, ".exec_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, ".exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    if (!load) check({tag, ".alu_ch"}, 32'(alu_ch), 32'(op));
    @(posedge clk); #1;
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    check({tag, ".rsp_flags"}, 32'(bus.rsp_flags & fmask), 32'(exp_flags & fmask));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, ".hold_data"}, 32'(bus.rsp_data), 32'(exp_data));
      check({tag, ".hold_flags"}, 32'(bus.rsp_flags & fmask), 32'(exp_flags & fmask));
      check({tag, ".hold_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst.rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst.alu_a", 32'(alu_a), 32'd0);
    check("rst.alu_ch", 32'(alu_ch), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 3+5 is a signed overflow in 4 bits; over is the ALU's call, so only zero/cout compared.
    do_cmd("t1.ld_r1", 1, 3'b000, 2'd1, 2'd0, 2'd0, 4'd3, 4'd3, 3'b000, 3'b111, 0);
    do_cmd("t1.ld_r2", 1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd5, 4'd5, 3'b000, 3'b111, 0);
    do_cmd("t1.add_r0", 0, 3'b000, 2'd0, 2'd1, 2'd2, 4'd0, 4'd8, 3'b000, 3'b101, 0);
    do_cmd("t1.or_r0", 0, 3'b100, 2'd3, 2'd0, 2'd0, 4'd0, 4'd8, 3'b000, 3'b100, 0);

    do_cmd("t2.ld_r1", 1, 3'b000, 2'd1, 2'd0, 2'd0, 4'd7, 4'd7, 3'b000, 3'b111, 0);
    do_cmd("t2.ld_r2", 1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd1, 4'd1, 3'b000, 3'b111, 0);
    do_cmd("t2.add_r3", 0, 3'b000, 2'd3, 2'd1, 2'd2, 4'd0, 4'b1000, 3'b010, 3'b111, 0);

    do_cmd("t3.ld_r1", 1, 3'b000, 2'd1, 2'd0, 2'd0, 4'd6, 4'd6, 3'b000, 3'b111, 0);
    do_cmd("t3.sub_r2", 0, 3'b001, 2'd2, 2'd1, 2'd1, 4'd0, 4'd0, 3'b101, 3'b111, 0);

    do_cmd("t4.ld_r1", 1, 3'b000, 2'd1, 2'd0, 2'd0, 4'b1110, 4'b1110, 3'b000, 3'b111, 0);
    do_cmd("t4.ld_r2", 1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd1, 4'd1, 3'b000, 3'b111, 0);
    do_cmd("t4.slt_r3", 0, 3'b110, 2'd3, 2'd1, 2'd2, 4'd0, 4'd1, 3'b000, 3'b100, 0);
    do_cmd("t4.eq_r3", 0, 3'b111, 2'd3, 2'd1, 2'd2, 4'd0, 4'd0, 3'b100, 3'b100, 0);
    do_cmd("t4.ld_zero", 1, 3'b000, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 3'b100, 3'b111, 0);

    // r1=1110, r2=1: xor gives 1111 and the response is stalled three cycles.
    do_cmd("t5.xor_hold", 0, 3'b101, 2'd3, 2'd1, 2'd2, 4'd0, 4'b1111, 3'b000, 3'b100, 3);
    // rd == rs1: operand reads the old r1 (1110), so 1110 & 0001 = 0 is written to r1.
    do_cmd("t5.and_rd_rs1", 0, 3'b011, 2'd1, 2'd1, 2'd2, 4'd0, 4'd0, 3'b100, 3'b100, 0);
    do_cmd("t5.not_r1", 0, 3'b010, 2'd0, 2'd1, 2'd1, 4'd0, 4'b1111, 3'b000, 3'b100, 0);

    do_cmd("t6.ld_r0", 1, 3'b000, 2'd0, 2'd0, 2'd0, 4'd9, 4'd9, 3'b000, 3'b111, 0);
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_rd    = 2'd0;
    bus.cmd_rs1   = 2'd1;
    bus.cmd_rs2   = 2'd2;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6.rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6.rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6.idle_after_rst", 32'(bus.cmd_ready), 32'd1);
    check("t6.no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
    // r0 was 9 before reset; reading it back through the ALU must now give 0.
    do_cmd("t6.or_r0", 0, 3'b100, 2'd3, 2'd0, 2'd0, 4'd0, 4'd0, 3'b100, 3'b100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
